// File: rtl/clock_field_editor.sv
// Push-button editor for an N-field time/date register set: loads one field, steps it
// within that field's own range (binary or packed BCD) and writes changed values back.
module clock_field_editor #(
   parameter int                            NUM_FIELDS    = 4,
   parameter int                            FIELD_W       = 8,
   parameter int                            SEL_W         = 2,
   parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MIN     = {8'd0, 8'd0, 8'd0, 8'd0},
   parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MAX     = {8'h01, 8'h12, 8'h59, 8'h59},
   parameter int                            BCD           = 1,
   parameter int                            TIMEOUT_TICKS = 30
) (
   input  logic                          i_clk,
   input  logic                          i_reset_n,
   input  logic                          i_ena,
   input  logic                          i_sec_tick,
   input  logic                          i_edit_pulse,
   input  logic                          i_abort_pulse,
   input  logic                          i_val_inc_pulse,
   input  logic                          i_val_dec_pulse,
   input  logic                          i_sel_inc_pulse,
   input  logic                          i_sel_dec_pulse,
   input  logic [NUM_FIELDS*FIELD_W-1:0] i_fields,
   output logic                          o_editing,
   output logic [SEL_W-1:0]              o_sel,
   output logic [FIELD_W-1:0]            o_val,
   output logic                          o_blink,
   output logic                          o_wr_pulse,
   output logic [SEL_W-1:0]              o_wr_sel,
   output logic [FIELD_W-1:0]            o_wr_val
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_EDIT   = 2'd2;
   localparam logic [1:0] S_COMMIT = 2'd3;

   localparam int NUM_SLOTS = 2 ** SEL_W;
   localparam int NIBBLES   = FIELD_W / 4;
   localparam int TMO_W     = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

   localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);
   localparam logic [TMO_W-1:0]   TMO_ONE   = TMO_W'(1);
   localparam logic [SEL_W-1:0]   SEL_LAST  = SEL_W'(NUM_FIELDS - 1);
   localparam logic [SEL_W-1:0]   SEL_ONE   = SEL_W'(1);
   localparam logic [FIELD_W-1:0] FIELD_ONE = FIELD_W'(1);

   function automatic logic is_bcd(input logic [FIELD_W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int n = 0; n < NIBBLES; n++)
         if (v[n*4 +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   // Digit-serial +/-1: a digit wrapping 9->0 (or 0->9) ripples into the next one.
   function automatic logic [FIELD_W-1:0] bcd_step(input logic [FIELD_W-1:0] v, input logic up);
      logic [FIELD_W-1:0] r;
      logic               carry;
      r     = v;
      carry = 1'b1;
      for (int n = 0; n < NIBBLES; n++) begin
         if (carry) begin
            if (up) begin
               if (r[n*4 +: 4] == 4'd9) r[n*4 +: 4] = 4'd0;
               else begin r[n*4 +: 4] = r[n*4 +: 4] + 4'd1; carry = 1'b0; end
            end else begin
               if (r[n*4 +: 4] == 4'd0) r[n*4 +: 4] = 4'd9;
               else begin r[n*4 +: 4] = r[n*4 +: 4] - 4'd1; carry = 1'b0; end
            end
         end
      end
      return r;
   endfunction

   logic [1:0]         r_state;
   logic [SEL_W-1:0]   r_sel;
   logic [FIELD_W-1:0] r_val;
   logic               r_dirty;
   logic [TMO_W-1:0]   r_tmo;
   logic               r_blink;
   logic               r_editing;
   logic               r_wr_pulse;
   logic [SEL_W-1:0]   r_wr_sel;
   logic [FIELD_W-1:0] r_wr_val;

   logic [FIELD_W-1:0] w_live [NUM_SLOTS];
   logic [FIELD_W-1:0] w_min  [NUM_SLOTS];
   logic [FIELD_W-1:0] w_max  [NUM_SLOTS];

   always_comb begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
         w_live[k] = '0;
         w_min[k]  = '0;
         w_max[k]  = '0;
      end
      for (int k = 0; k < NUM_FIELDS; k++) begin
         w_live[k] = i_fields[k*FIELD_W +: FIELD_W];
         w_min[k]  = FIELD_MIN[k*FIELD_W +: FIELD_W];
         w_max[k]  = FIELD_MAX[k*FIELD_W +: FIELD_W];
      end
   end

   logic w_edit, w_abort, w_val_inc, w_val_dec, w_sel_inc, w_sel_dec;
   logic w_sel_step, w_val_step, w_tmo_hit, w_in_range, w_write;
   logic [FIELD_W-1:0] w_live_cur, w_min_cur, w_max_cur, w_load_val, w_val_next;
   logic [SEL_W-1:0]   w_sel_next;
   logic [1:0]         w_state_nxt;

   assign w_edit     = i_edit_pulse    & i_ena;
   assign w_abort    = i_abort_pulse   & i_ena;
   assign w_val_inc  = i_val_inc_pulse & i_ena;
   assign w_val_dec  = i_val_dec_pulse & i_ena;
   assign w_sel_inc  = i_sel_inc_pulse & i_ena;
   assign w_sel_dec  = i_sel_dec_pulse & i_ena;
   assign w_sel_step = w_sel_inc ^ w_sel_dec;
   assign w_val_step = w_val_inc ^ w_val_dec;

   assign w_live_cur = w_live[r_sel];
   assign w_min_cur  = w_min[r_sel];
   assign w_max_cur  = w_max[r_sel];
   assign w_in_range = (w_live_cur >= w_min_cur) && (w_live_cur <= w_max_cur) &&
                       ((BCD == 0) || is_bcd(w_live_cur));
   assign w_load_val = w_in_range ? w_live_cur : w_min_cur;
   assign w_tmo_hit  = (TIMEOUT_TICKS != 0) && i_sec_tick && (r_tmo == TMO_LAST);

   always_comb begin
      if (w_sel_inc) w_sel_next = (r_sel == SEL_LAST) ? '0 : r_sel + SEL_ONE;
      else           w_sel_next = (r_sel == '0) ? SEL_LAST : r_sel - SEL_ONE;
   end

   always_comb begin
      if (w_val_inc)
         w_val_next = (r_val == w_max_cur) ? w_min_cur :
                      (BCD != 0) ? bcd_step(r_val, 1'b1) : r_val + FIELD_ONE;
      else
         w_val_next = (r_val == w_min_cur) ? w_max_cur :
                      (BCD != 0) ? bcd_step(r_val, 1'b0) : r_val - FIELD_ONE;
   end

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_edit) w_state_nxt = S_LOAD;
         S_LOAD:   w_state_nxt = S_EDIT;
         S_EDIT: begin
            if (w_abort)                      w_state_nxt = S_IDLE;
            else if (w_edit)                  w_state_nxt = S_COMMIT;
            else if (w_sel_step)              w_state_nxt = S_LOAD;
            else if (!w_val_step && w_tmo_hit) w_state_nxt = S_IDLE;
         end
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // A field is written back on commit, or when the operator moves off a changed field.
   assign w_write = r_dirty && ((r_state == S_COMMIT) ||
                    ((r_state == S_EDIT) && !w_abort && !w_edit && w_sel_step));

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state    <= S_IDLE;
         r_sel      <= '0;
         r_val      <= '0;
         r_dirty    <= 1'b0;
         r_tmo      <= '0;
         r_blink    <= 1'b0;
         r_editing  <= 1'b0;
         r_wr_pulse <= 1'b0;
         r_wr_sel   <= '0;
         r_wr_val   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_editing  <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_EDIT);
         r_blink    <= (r_state == S_EDIT) && (w_state_nxt == S_EDIT) && (r_blink ^ i_sec_tick);
         r_wr_pulse <= w_write;
         if (w_write) begin
            r_wr_sel <= r_sel;
            r_wr_val <= r_val;
         end
         case (r_state)
            S_IDLE: begin
               r_val <= w_live_cur;
               if (!w_edit && w_sel_step) r_sel <= w_sel_next;
            end
            S_LOAD: begin
               r_val   <= w_load_val;
               r_dirty <= 1'b0;
               r_tmo   <= '0;
            end
            S_EDIT: begin
               if (!w_abort && !w_edit) begin
                  if (w_sel_step) begin
                     r_sel <= w_sel_next;
                  end else if (w_val_step) begin
                     r_val   <= w_val_next;
                     r_dirty <= 1'b1;
                     r_tmo   <= '0;
                  end else if (i_sec_tick && (TIMEOUT_TICKS != 0)) begin
                     r_tmo <= r_tmo + TMO_ONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_editing  = r_editing;
   assign o_sel      = r_sel;
   assign o_val      = r_val;
   assign o_blink    = r_blink;
   assign o_wr_pulse = r_wr_pulse;
   assign o_wr_sel   = r_wr_sel;
   assign o_wr_val   = r_wr_val;

endmodule

// File: doc/clock_field_editor.md
Name: clock_field_editor

Overview:
- Parametrised editor for an N-field time/date register set, e.g. ss/mm/hh/pm or dd/mo/yy.
- Sits between the debounced push-button pulse logic and the timekeeping counters.
- Operator enters edit mode, steps between fields, and increments or decrements each field within its own min/max range (binary or BCD).
- Changed fields are written back as single-cycle write strobes; an edit session can be aborted explicitly or by inactivity timeout.

Parameters:
NUM_FIELDS, 4, number of editable fields (2..16; need not be a power of 2)
FIELD_W, 8, bits per field
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_FIELDS
FIELD_MIN, {8'd0,8'd0,8'd0,8'd0}, packed per-field minimum, field 0 in LSBs
FIELD_MAX, {8'h01,8'h12,8'h59,8'h59}, packed per-field maximum, field 0 in LSBs
BCD, 1, 1 = fields are packed BCD (two digits per byte), 0 = binary
TIMEOUT_TICKS, 30, i_sec_tick count with no button activity before auto-abort; 0 = never

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  synchronous reset, active low
i_ena  in  1  qualifies all button pulses; pulses with i_ena=0 are ignored
i_sec_tick  in  1  one-cycle tick (1 Hz nominal) for blink and timeout
i_edit_pulse  in  1  enter edit / commit-and-exit
i_abort_pulse  in  1  exit without writing the current field
i_val_inc_pulse  in  1  increment working value
i_val_dec_pulse  in  1  decrement working value
i_sel_inc_pulse  in  1  next field
i_sel_dec_pulse  in  1  previous field
i_fields  in  NUM_FIELDS*FIELD_W  live field values, field 0 in LSBs
o_editing  out  1  high while in LOAD or EDIT
o_sel  out  SEL_W  currently selected field
o_val  out  FIELD_W  displayed value: live field in IDLE, working value in EDIT
o_blink  out  1  display blank phase for the selected field
o_wr_pulse  out  1  one-cycle write strobe
o_wr_sel  out  SEL_W  field index accompanying o_wr_pulse
o_wr_val  out  FIELD_W  value accompanying o_wr_pulse

Behaviour:
- Single clock domain.
- Reset when i_reset_n=0 at a rising edge; reset overrides everything, including a session mid-edit with no write.
- Reset values: state IDLE; o_sel, o_val, o_wr_sel, o_wr_val all 0; o_editing, o_blink, o_wr_pulse 0; dirty flag 0; timeout counter 0.
- A "pulse" below means input high AND i_ena high.
- States: IDLE, LOAD, EDIT, COMMIT.
- IDLE:
  - o_val <= i_fields[o_sel] every cycle (1-cycle latency).
  - Sel pulses change o_sel, with wrap, for viewing.
  - Edit pulse -> LOAD.
  - All other pulses ignored.
- LOAD (exactly 1 cycle):
  - Working value <= i_fields[o_sel]; if it is outside [MIN,MAX] of that field, or is invalid BCD when BCD=1, load MIN.
  - Dirty <= 0, timeout counter <= 0.
  - -> EDIT.
- EDIT, priority per cycle: abort > edit > sel > val.
  - Abort: -> IDLE, no write.
  - Edit: -> COMMIT.
  - Sel inc XOR sel dec:
    - If dirty, o_wr_pulse=1 next cycle with the old o_sel and the working value.
    - o_sel advances: inc from NUM_FIELDS-1 -> 0; dec from 0 -> NUM_FIELDS-1.
    - -> LOAD.
    - Any val pulse in the same cycle is dropped.
  - Sel inc AND sel dec together: ignored; val pulses still evaluated.
  - Val inc XOR val dec:
    - inc: value==MAX -> MIN, else +1.
    - dec: value==MIN -> MAX, else -1.
    - BCD=1: low digit wraps 9->0 with carry and 0->9 with borrow.
    - Dirty <= 1.
  - Val inc AND val dec together: no change, dirty unchanged.
  - Any accepted pulse clears the timeout counter.
  - Otherwise each i_sec_tick increments the counter; reaching TIMEOUT_TICKS (if nonzero) behaves as abort.
- COMMIT (1 cycle):
  - If dirty, o_wr_pulse=1 with o_wr_sel=o_sel and o_wr_val=working value.
  - -> IDLE.
- o_wr_pulse is registered and high for exactly one cycle per write. o_wr_sel and o_wr_val hold their last values otherwise.
- o_sel persists across sessions.
- o_blink:
  - Toggles on each i_sec_tick while in EDIT.
  - Forced 0 on entry to LOAD and in IDLE/COMMIT.
- o_editing = (state==LOAD or EDIT), registered.

Test Plan:
- Reset with i_reset_n=0 for 2 cycles while i_ena=1 and i_edit_pulse=1 -> all outputs 0, state IDLE; assert also mid-EDIT with a dirty field -> no o_wr_pulse.
- Field 0 live=8'h58: edit, inc, inc, edit -> working 59 then 00 (BCD wrap); exactly one o_wr_pulse with o_wr_sel=0, o_wr_val=8'h00; o_editing falls.
- Field 2 (max 12): dec from 8'h00 -> 8'h12; sel inc from field 3 -> o_sel=0; sel dec from 0 -> o_sel=3; entering with live hh=8'h1A -> working loads 8'h00.
- Edit field 1 (8'h30), inc to 8'h31, sel inc -> o_wr_pulse (sel=1, 8'h31), o_sel=2; edit again with no val change -> no write.
- Simultaneous: val inc+dec -> unchanged; abort+edit in the same cycle -> IDLE with no write; i_ena=0 with any pulse -> no effect.
- TIMEOUT_TICKS=3: edit, inc, then 3 i_sec_ticks with no buttons -> IDLE, no write, o_blink toggled at each tick then 0; repeat with TIMEOUT_TICKS=0 and 100 ticks -> still EDIT.
